edge_event_arbiter: RTL and testbench

// Collects single-cycle rising-edge pulses from N_CH edge_detector instances.

---
 rtl/edge_event_arbiter.sv | 101 ++++++++++
 tb/tb_edge_event_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/edge_event_arbiter.sv
// Queues one pending rising-edge event per channel and serialises them onto a
// valid/ready port with round-robin priority; counts edges lost to a full queue.
module edge_event_arbiter #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         edge_in,
  input  logic [N_CH-1:0]         ch_en,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [$clog2(N_CH)-1:0] evt_ch,
  output logic                    evt_ovf,
  output logic [CNT_W-1:0]        drop_cnt,
  input  logic                    clr_drop,
  output logic                    busy
);

  localparam int IDX_W = $clog2(N_CH);
  localparam int PC_W  = $clog2(N_CH + 1);
  localparam int SUM_W = CNT_W + PC_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_CH-1:0]  pend, ovf;
  logic [IDX_W-1:0] last;

  logic [N_CH-1:0]  edge_v, req, gnt_vec, drop_vec, pend_nxt, ovf_nxt;
  logic [IDX_W-1:0] gnt_idx;
  logic             found, slot_free, take;
  logic [PC_W-1:0]  n_drop;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] drop_sat;

  assign edge_v    = edge_in & ch_en;
  // A channel being masked this cycle is discarded rather than granted.
  assign req       = pend & ch_en;
  assign slot_free = !evt_valid || evt_ready;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 1; k <= N_CH; k++) begin
      int idx;
      idx = (int'(last) + k) % N_CH;
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = IDX_W'(idx);
      end
    end
  end

  assign take = slot_free && found;

  always_comb begin
    gnt_vec = '0;
    if (take) gnt_vec[gnt_idx] = 1'b1;
  end

  // A fresh edge on the channel being granted re-arms it instead of dropping.
  assign drop_vec = edge_v & pend & ~gnt_vec;
  assign pend_nxt = ch_en & ((pend & ~gnt_vec) | edge_v);
  assign ovf_nxt  = ch_en & ((ovf & ~gnt_vec) | drop_vec);

  always_comb begin
    n_drop = '0;
    for (int i = 0; i < N_CH; i++) n_drop = n_drop + PC_W'(drop_vec[i]);
    sum      = SUM_W'(drop_cnt) + SUM_W'(n_drop);
    drop_sat = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend      <= '0;
      ovf       <= '0;
      last      <= IDX_W'(N_CH - 1);
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      evt_ovf   <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      pend <= pend_nxt;
      ovf  <= ovf_nxt;
      if (slot_free) begin
        evt_valid <= take;
        if (take) begin
          evt_ch  <= gnt_idx;
          evt_ovf <= ovf[gnt_idx];
          last    <= gnt_idx;
        end
      end
      if (clr_drop)
        drop_cnt <= '0;
      else if (|drop_vec)
        drop_cnt <= drop_sat;
    end
  end

  assign busy = evt_valid || (|pend);

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed vector table plus hand-written sequences for saturation, clear and async reset.
module tb_edge_event_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] edge_in = '0;
  logic [3:0] ch_en = 4'b1111;
  logic       evt_valid;
  logic       evt_ready = 1'b1;
  logic [1:0] evt_ch;
  logic       evt_ovf;
  logic [7:0] drop_cnt;
  logic       clr_drop = 1'b0;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  edge_event_arbiter #(.N_CH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .edge_in(edge_in), .ch_en(ch_en),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch),
    .evt_ovf(evt_ovf), .drop_cnt(drop_cnt), .clr_drop(clr_drop), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rstv;
    logic [3:0] e;
    logic [3:0] en;
    logic       rdy;
    logic       clr;
    logic       xv;
    logic [1:0] xch;
    logic       xovf;
    logic       xbusy;
    logic [7:0] xdrop;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rstv, input logic [3:0] e, input logic [3:0] en,
                     input logic rdy, input logic clr, input logic xv,
                     input logic [1:0] xch, input logic xovf, input logic xbusy,
                     input logic [7:0] xdrop);
    vec_t v;
    v.rstv = rstv; v.e = e; v.en = en; v.rdy = rdy; v.clr = clr;
    v.xv = xv; v.xch = xch; v.xovf = xovf; v.xbusy = xbusy; v.xdrop = xdrop;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic cycle(input logic [3:0] e, input logic [3:0] en, input logic rdy,
                       input logic clr);
    edge_in = e; ch_en = en; evt_ready = rdy; clr_drop = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with edges toggling: everything stays quiet
    for (int i = 0; i < 4; i++) begin
      cycle((i % 2 == 0) ? 4'b1111 : 4'b0101, 4'b1111, 1'b1, 1'b0);
      check("rst_valid", i, int'(evt_valid), 0);
      check("rst_busy",  i, int'(busy), 0);
      check("rst_drop",  i, int'(drop_cnt), 0);
    end
    rst = 1'b1;

    //   rst  edge     en      rdy  clr  xv  ch  ovf busy drop
    add(1, 4'b0100, 4'b1111, 1, 0,  0, 0, 0, 1, 0);   // single pulse ch2
    add(1, 4'b0000, 4'b1111, 1, 0,  1, 2, 0, 1, 0);
    add(1, 4'b0000, 4'b1111, 1, 0,  0, 0, 0, 0, 0);
    add(0, 4'b0000, 4'b1111, 1, 0,  0, 0, 0, 0, 0);   // reset: last back to 3
    add(1, 4'b1111, 4'b1111, 1, 0,  0, 0, 0, 1, 0);   // all four at once
    add(1, 4'b0000, 4'b1111, 1, 0,  1, 0, 0, 1, 0);
    add(1, 4'b0000, 4'b1111, 1, 0,  1, 1, 0, 1, 0);
    add(1, 4'b0000, 4'b1111, 1, 0,  1, 2, 0, 1, 0);
    add(1, 4'b0000, 4'b1111, 1, 0,  1, 3, 0, 1, 0);
    add(1, 4'b1001, 4'b1111, 1, 0,  0, 0, 0, 1, 0);   // ch0+ch3 with last=3
    add(1, 4'b0000, 4'b1111, 1, 0,  1, 0, 0, 1, 0);
    add(1, 4'b0000, 4'b1111, 1, 0,  1, 3, 0, 1, 0);
    add(1, 4'b0000, 4'b1111, 1, 0,  0, 0, 0, 0, 0);
    add(1, 4'b0010, 4'b1111, 0, 0,  0, 0, 0, 1, 0);   // ch1 pulses, ready low
    add(1, 4'b0000, 4'b1111, 0, 0,  1, 1, 0, 1, 0);
    add(1, 4'b0010, 4'b1111, 0, 0,  1, 1, 0, 1, 0);
    add(1, 4'b0000, 4'b1111, 0, 0,  1, 1, 0, 1, 0);
    add(1, 4'b0010, 4'b1111, 0, 0,  1, 1, 0, 1, 1);   // third pulse drops
    add(1, 4'b0000, 4'b1111, 1, 0,  1, 1, 1, 1, 1);   // re-grant carries ovf
    add(1, 4'b0000, 4'b1111, 1, 0,  0, 0, 0, 0, 1);
    add(1, 4'b1111, 4'b1101, 1, 0,  0, 0, 0, 1, 1);   // ch1 masked
    add(1, 4'b0000, 4'b1101, 1, 0,  1, 2, 0, 1, 1);
    add(1, 4'b0000, 4'b1101, 1, 0,  1, 3, 0, 1, 1);
    add(1, 4'b0000, 4'b1101, 1, 0,  1, 0, 0, 1, 1);
    add(1, 4'b0000, 4'b1101, 1, 0,  0, 0, 0, 0, 1);
    add(1, 4'b0100, 4'b1111, 0, 0,  0, 0, 0, 1, 1);   // pend ch2 then mask it
    add(1, 4'b0000, 4'b1011, 0, 0,  0, 0, 0, 0, 1);
    add(1, 4'b0001, 4'b1111, 1, 0,  0, 0, 0, 1, 1);   // edge coincident with grant
    add(1, 4'b0001, 4'b1111, 1, 0,  1, 0, 0, 1, 1);
    add(1, 4'b0000, 4'b1111, 1, 0,  1, 0, 0, 1, 1);
    add(1, 4'b0000, 4'b1111, 1, 0,  0, 0, 0, 0, 1);
    add(1, 4'b0110, 4'b1111, 0, 0,  0, 0, 0, 1, 1);   // two-channel drops
    add(1, 4'b0110, 4'b1111, 0, 0,  1, 1, 0, 1, 2);
    add(1, 4'b0110, 4'b1111, 0, 0,  1, 1, 0, 1, 4);
    add(1, 4'b0000, 4'b1111, 1, 0,  1, 2, 1, 1, 4);
    add(1, 4'b0000, 4'b1111, 1, 0,  1, 1, 1, 1, 4);
    add(1, 4'b0000, 4'b1111, 1, 0,  0, 0, 0, 0, 4);

    foreach (vecs[i]) begin
      rst = vecs[i].rstv;
      cycle(vecs[i].e, vecs[i].en, vecs[i].rdy, vecs[i].clr);
      check("valid", i, int'(evt_valid), int'(vecs[i].xv));
      check("busy",  i, int'(busy), int'(vecs[i].xbusy));
      check("drop",  i, int'(drop_cnt), int'(vecs[i].xdrop));
      if (vecs[i].xv) begin
        check("ch",  i, int'(evt_ch), int'(vecs[i].xch));
        check("ovf", i, int'(evt_ovf), int'(vecs[i].xovf));
      end
    end
    rst = 1'b1;

    // Saturation: ready low, all channels edging every cycle
    for (int i = 1; i <= 80; i++) begin
      cycle(4'b1111, 4'b1111, 1'b0, 1'b0);
      if (i == 10) check("drop_mid", i, int'(drop_cnt), 39);
    end
    check("drop_sat", 80, int'(drop_cnt), 255);
    check("hold_valid", 80, int'(evt_valid), 1);
    check("hold_ch", 80, int'(evt_ch), 2);

    cycle(4'b1111, 4'b1111, 1'b0, 1'b1);   // clear beats coincident drops
    check("clr", 0, int'(drop_cnt), 0);
    cycle(4'b0000, 4'b1111, 1'b0, 1'b0);
    check("clr_hold", 1, int'(drop_cnt), 0);
    cycle(4'b1111, 4'b1111, 1'b0, 1'b0);
    check("drop_after_clr", 2, int'(drop_cnt), 4);

    // Async reset while an event is presented
    check("pre_rst_valid", 0, int'(evt_valid), 1);
    edge_in = '0;
    #2 rst = 1'b0;
    #1;
    check("async_valid", 0, int'(evt_valid), 0);
    check("async_busy",  0, int'(busy), 0);
    check("async_drop",  0, int'(drop_cnt), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    cycle(4'b0000, 4'b1111, 1'b1, 1'b0);
    check("post_rst_valid", 1, int'(evt_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
